// File: rtl/gray_pkg.sv
// Shared types and reference Gray/binary helpers for the position tracker.
package gray_pkg;

   localparam int GRAY_WIDTH = 4;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_e;

   // Prefix-XOR form: each binary bit is the parity of all Gray bits at or above it.
   function automatic logic [GRAY_WIDTH-1:0] gray2bin(input logic [GRAY_WIDTH-1:0] g);
      logic [GRAY_WIDTH-1:0] b;
      b = '0;
      for (int i = 0; i < GRAY_WIDTH; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   function automatic logic [GRAY_WIDTH-1:0] bin2gray(input logic [GRAY_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter, MSB-first ripple form.
module gray2bin_conv
   import gray_pkg::*;
#(
   parameter int WIDTH = GRAY_WIDTH
) (
   input  logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] b
);

   logic [WIDTH-1:0] acc;

   always_comb begin
      acc = '0;
      acc[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         acc[i] = acc[i+1] ^ g[i];
      end
      b = acc;
   end

endmodule

// File: rtl/gray_position_tracker.sv
// Synchronizes, debounces and decodes a Gray-coded position; tracks steps,
// direction, revolutions and illegal jumps.
//
//   state | meaning
//   INIT  | waiting for first stable code to load pos
//   TRACK | locked; accepted codes must be +/-1 from pos
//   FAULT | illegal jump seen; next stable code re-locks without a step
module gray_position_tracker
   import gray_pkg::*;
#(
   parameter int WIDTH  = GRAY_WIDTH,
   parameter int TURN_W = 8,
   parameter int FILT   = 3,
   parameter int ERR_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [WIDTH-1:0]  gray_in,
   output logic [WIDTH-1:0]  pos,
   output logic [TURN_W-1:0] turns,
   output logic              dir,
   output logic              step,
   output logic              err,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              locked
);

   localparam int FCW = $clog2(FILT + 1);
   localparam logic [FCW-1:0] FILT_C = FCW'(FILT);

   logic [WIDTH-1:0]  s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
   logic [FCW-1:0]    fcnt_q, fcnt_d;
   logic              acc_q, acc_d;
   state_e            state_q, state_d;
   logic [WIDTH-1:0]  pos_q, pos_d;
   logic [TURN_W-1:0] turns_q, turns_d;
   logic              dir_q, dir_d, step_q, step_d, err_q, err_d, locked_q, locked_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]  bin, delta;

   gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
      .g (cand_q),
      .b (bin)
   );

   assign delta = bin - pos_q;

   // acc_q is a registered one-shot so the decision sees a settled candidate.
   always_comb begin
      s1_d   = gray_in;
      s2_d   = s1_q;
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      acc_d  = 1'b0;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         fcnt_d = '0;
      end else if (fcnt_q < FILT_C) begin
         fcnt_d = fcnt_q + FCW'(1);
         acc_d  = (fcnt_q == FILT_C - FCW'(1));
      end
   end

   always_comb begin
      state_d   = state_q;
      pos_d     = pos_q;
      turns_d   = turns_q;
      dir_d     = dir_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      locked_d  = locked_q;
      if (clear) begin
         state_d   = INIT;
         turns_d   = '0;
         err_cnt_d = '0;
         locked_d  = 1'b0;
      end else if (acc_q) begin
         case (state_q)
            INIT, FAULT: begin
               pos_d    = bin;
               locked_d = 1'b1;
               state_d  = TRACK;
            end
            TRACK: begin
               if (delta == WIDTH'(1)) begin
                  pos_d  = bin;
                  dir_d  = 1'b1;
                  step_d = 1'b1;
                  if (pos_q == '1) turns_d = turns_q + TURN_W'(1);
               end else if (delta == '1) begin
                  pos_d  = bin;
                  dir_d  = 1'b0;
                  step_d = 1'b1;
                  if (pos_q == '0) turns_d = turns_q - TURN_W'(1);
               end else if (delta != '0) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  state_d  = FAULT;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
               end
            end
            default: state_d = INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= '0;
         s2_q      <= '0;
         cand_q    <= '0;
         fcnt_q    <= '0;
         acc_q     <= 1'b0;
         state_q   <= INIT;
         pos_q     <= '0;
         turns_q   <= '0;
         dir_q     <= 1'b0;
         step_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         locked_q  <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cand_q    <= cand_d;
         fcnt_q    <= fcnt_d;
         acc_q     <= acc_d;
         state_q   <= state_d;
         pos_q     <= pos_d;
         turns_q   <= turns_d;
         dir_q     <= dir_d;
         step_q    <= step_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         locked_q  <= locked_d;
      end
   end

   assign pos     = pos_q;
   assign turns   = turns_q;
   assign dir     = dir_q;
   assign step    = step_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign locked  = locked_q;

endmodule
